// File: rtl/zmips_ex_stage_if.sv
//------------------------------------------------------------------------------
// Module      : zmips_ex_stage_if
// Description : ID/EX operands, forwarding taps, pipeline control and EX/MEM
//               results of the ZMIPS execute stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface zmips_ex_stage_if;
  logic        id_ex_valid;
  logic [5:0]  id_ex_opcode;
  logic [31:0] id_ex_reg_0;
  logic [31:0] id_ex_reg_1;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;
  logic [31:0] id_ex_imm_se;
  logic        id_ex_rfmt;
  logic        id_ex_alusrc;
  logic        id_ex_memrd;
  logic        id_ex_memwr;
  logic        id_ex_wrreg;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        mem_fwd_wrreg;
  logic [4:0]  mem_fwd_addr;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_wrreg;
  logic [4:0]  wb_fwd_addr;
  logic [31:0] wb_fwd_data;
  logic        stall;
  logic        flush;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu;
  logic [31:0] ex_mem_store_data;
  logic [4:0]  ex_mem_dst;
  logic        ex_mem_memrd;
  logic        ex_mem_memwr;
  logic        ex_mem_wrreg;
  logic        ex_mem_zero;
  logic        ex_flag_c;
  logic        ex_load_use;

  modport master (
    output id_ex_valid, id_ex_opcode, id_ex_reg_0, id_ex_reg_1,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_imm_se,
           id_ex_rfmt, id_ex_alusrc, id_ex_memrd, id_ex_memwr, id_ex_wrreg,
           id_rs, id_rt,
           mem_fwd_wrreg, mem_fwd_addr, mem_fwd_data,
           wb_fwd_wrreg, wb_fwd_addr, wb_fwd_data,
           stall, flush,
    input  ex_mem_valid, ex_mem_alu, ex_mem_store_data, ex_mem_dst,
           ex_mem_memrd, ex_mem_memwr, ex_mem_wrreg, ex_mem_zero,
           ex_flag_c, ex_load_use
  );

  modport slave (
    input  id_ex_valid, id_ex_opcode, id_ex_reg_0, id_ex_reg_1,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_imm_se,
           id_ex_rfmt, id_ex_alusrc, id_ex_memrd, id_ex_memwr, id_ex_wrreg,
           id_rs, id_rt,
           mem_fwd_wrreg, mem_fwd_addr, mem_fwd_data,
           wb_fwd_wrreg, wb_fwd_addr, wb_fwd_data,
           stall, flush,
    output ex_mem_valid, ex_mem_alu, ex_mem_store_data, ex_mem_dst,
           ex_mem_memrd, ex_mem_memwr, ex_mem_wrreg, ex_mem_zero,
           ex_flag_c, ex_load_use
  );
endinterface

`default_nettype wire

// File: rtl/zmips_ex_stage.sv
//------------------------------------------------------------------------------
// Module      : zmips_ex_stage
// Description : ZMIPS execute stage - operand forwarding, ALU, carry flag,
//               load-use detection and the falling-edge EX/MEM register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module zmips_ex_stage (
  input  logic              clk,
  input  logic              rst,
  zmips_ex_stage_if.slave   bus
);

  localparam logic [5:0] c_OP_AND  = 6'h01;
  localparam logic [5:0] c_OP_OR   = 6'h02;
  localparam logic [5:0] c_OP_XOR  = 6'h03;
  localparam logic [5:0] c_OP_SUB  = 6'h04;
  localparam logic [5:0] c_OP_ADD  = 6'h06;
  localparam logic [5:0] c_OP_SUBI = 6'h10;
  localparam logic [5:0] c_OP_ADDI = 6'h11;
  localparam logic [5:0] c_OP_BEQ  = 6'h12;
  localparam logic [5:0] c_OP_BNE  = 6'h13;
  localparam logic [5:0] c_OP_LW   = 6'h16;
  localparam logic [5:0] c_OP_SW   = 6'h17;
  localparam logic [5:0] c_OP_PASS = 6'h18;

  logic [31:0] w_op_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_op_b;
  logic [32:0] w_add;
  logic [32:0] w_sub;
  logic [31:0] w_alu;
  logic        w_carry;
  logic        w_flag_op;
  logic [4:0]  w_dst;

  logic        r_valid;
  logic [31:0] r_alu;
  logic [31:0] r_store_data;
  logic [4:0]  r_dst;
  logic        r_memrd;
  logic        r_memwr;
  logic        r_wrreg;
  logic        r_zero;
  logic        r_flag_c;

  // MEM result is younger than WB, so it wins; r0 is hard-wired and never forwarded.
  always_comb begin
    w_op_a = bus.id_ex_reg_0;
    if (bus.mem_fwd_wrreg && (bus.mem_fwd_addr == bus.id_ex_rs) && (bus.id_ex_rs != 5'd0))
      w_op_a = bus.mem_fwd_data;
    else if (bus.wb_fwd_wrreg && (bus.wb_fwd_addr == bus.id_ex_rs) && (bus.id_ex_rs != 5'd0))
      w_op_a = bus.wb_fwd_data;
  end

  always_comb begin
    w_fwd_b = bus.id_ex_reg_1;
    if (bus.mem_fwd_wrreg && (bus.mem_fwd_addr == bus.id_ex_rt) && (bus.id_ex_rt != 5'd0))
      w_fwd_b = bus.mem_fwd_data;
    else if (bus.wb_fwd_wrreg && (bus.wb_fwd_addr == bus.id_ex_rt) && (bus.id_ex_rt != 5'd0))
      w_fwd_b = bus.wb_fwd_data;
  end

  assign w_op_b = bus.id_ex_alusrc ? bus.id_ex_imm_se : w_fwd_b;

  // Subtract as A + ~B + 1 so bit 32 is the "no borrow" carry.
  assign w_add = {1'b0, w_op_a} + {1'b0, w_op_b};
  assign w_sub = {1'b0, w_op_a} + {1'b0, ~w_op_b} + 33'd1;

  always_comb begin
    w_alu   = 32'd0;
    w_carry = 1'b0;
    case (bus.id_ex_opcode)
      c_OP_AND: w_alu = w_op_a & w_op_b;
      c_OP_OR:  w_alu = w_op_a | w_op_b;
      c_OP_XOR: w_alu = w_op_a ^ w_op_b;
      c_OP_SUB, c_OP_SUBI, c_OP_BEQ, c_OP_BNE: begin
        w_alu   = w_sub[31:0];
        w_carry = w_sub[32];
      end
      c_OP_ADD, c_OP_ADDI, c_OP_LW, c_OP_SW: begin
        w_alu   = w_add[31:0];
        w_carry = w_add[32];
      end
      c_OP_PASS: w_alu = w_op_a;
      default:   w_alu = 32'd0;
    endcase
  end

  assign w_flag_op = (bus.id_ex_opcode == c_OP_SUB)  || (bus.id_ex_opcode == c_OP_ADD) ||
                     (bus.id_ex_opcode == c_OP_SUBI) || (bus.id_ex_opcode == c_OP_ADDI);

  assign w_dst = bus.id_ex_rfmt ? bus.id_ex_rd : bus.id_ex_rt;

  // Purely a function of ID/EX and ID contents; the hazard unit owns stall/flush.
  assign bus.ex_load_use = bus.id_ex_valid && bus.id_ex_memrd && (w_dst != 5'd0) &&
                           ((w_dst == bus.id_rs) || (w_dst == bus.id_rt));

  always_ff @(negedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_alu        <= 32'd0;
      r_store_data <= 32'd0;
      r_dst        <= 5'd0;
      r_memrd      <= 1'b0;
      r_memwr      <= 1'b0;
      r_wrreg      <= 1'b0;
      r_zero       <= 1'b0;
      r_flag_c     <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_memrd <= 1'b0;
      r_memwr <= 1'b0;
      r_wrreg <= 1'b0;
    end else if (!bus.stall) begin
      r_valid      <= bus.id_ex_valid;
      r_alu        <= w_alu;
      r_store_data <= w_fwd_b;
      r_dst        <= w_dst;
      r_memrd      <= bus.id_ex_memrd & bus.id_ex_valid;
      r_memwr      <= bus.id_ex_memwr & bus.id_ex_valid;
      r_wrreg      <= bus.id_ex_wrreg & bus.id_ex_valid;
      r_zero       <= (w_alu == 32'd0);
      if (bus.id_ex_valid && w_flag_op)
        r_flag_c <= w_carry;
    end
  end

  assign bus.ex_mem_valid      = r_valid;
  assign bus.ex_mem_alu        = r_alu;
  assign bus.ex_mem_store_data = r_store_data;
  assign bus.ex_mem_dst        = r_dst;
  assign bus.ex_mem_memrd      = r_memrd;
  assign bus.ex_mem_memwr      = r_memwr;
  assign bus.ex_mem_wrreg      = r_wrreg;
  assign bus.ex_mem_zero       = r_zero;
  assign bus.ex_flag_c         = r_flag_c;

endmodule

`default_nettype wire

// File: tb/tb_zmips_ex_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_zmips_ex_stage
// Description : Directed and randomized checks of zmips_ex_stage against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_zmips_ex_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  zmips_ex_stage_if bus ();

  zmips_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference EX/MEM state
  logic        m_valid, m_rd, m_wr, m_wrreg, m_zero, m_c;
  logic [31:0] m_alu, m_sd;
  logic [4:0]  m_dst;

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 0) return v;
    if (bus.mem_fwd_wrreg && bus.mem_fwd_addr == r) return bus.mem_fwd_data;
    if (bus.wb_fwd_wrreg && bus.wb_fwd_addr == r) return bus.wb_fwd_data;
    return v;
  endfunction

  function automatic logic exp_load_use();
    logic [4:0] d;
    d = bus.id_ex_rfmt ? bus.id_ex_rd : bus.id_ex_rt;
    return bus.id_ex_valid && bus.id_ex_memrd && d != 0 && (d == bus.id_rs || d == bus.id_rt);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, 32'(bus.ex_mem_valid), 32'(m_valid));
    check({tag, "_alu"},   bus.ex_mem_alu, m_alu);
    check({tag, "_sd"},    bus.ex_mem_store_data, m_sd);
    check({tag, "_dst"},   32'(bus.ex_mem_dst), 32'(m_dst));
    check({tag, "_memrd"}, 32'(bus.ex_mem_memrd), 32'(m_rd));
    check({tag, "_memwr"}, 32'(bus.ex_mem_memwr), 32'(m_wr));
    check({tag, "_wrreg"}, 32'(bus.ex_mem_wrreg), 32'(m_wrreg));
    check({tag, "_zero"},  32'(bus.ex_mem_zero), 32'(m_zero));
    check({tag, "_flagc"}, 32'(bus.ex_flag_c), 32'(m_c));
  endtask

  // Evaluates the model from the current inputs, clocks the DUT, then compares.
  task automatic tick(input string tag, input bit data_cmp);
    logic [31:0] a, b, fb, r;
    logic        c, cop, n_valid, n_rd, n_wr, n_wrreg, n_zero, n_c;
    logic [31:0] n_alu, n_sd;
    logic [4:0]  n_dst;
    longint unsigned s;
    a  = fwd(bus.id_ex_rs, bus.id_ex_reg_0);
    fb = fwd(bus.id_ex_rt, bus.id_ex_reg_1);
    b  = bus.id_ex_alusrc ? bus.id_ex_imm_se : fb;
    r = 0; c = 0;
    case (bus.id_ex_opcode)
      6'h01: r = a & b;
      6'h02: r = a | b;
      6'h03: r = a ^ b;
      6'h04, 6'h10, 6'h12, 6'h13: begin r = a - b; c = (a >= b); end
      6'h06, 6'h11, 6'h16, 6'h17: begin
        s = longint'(a) + longint'(b);
        r = a + b;
        c = (s > 64'hFFFF_FFFF);
      end
      6'h18: r = a;
      default: r = 0;
    endcase
    cop = bus.id_ex_opcode inside {6'h04, 6'h06, 6'h10, 6'h11};
    {n_valid, n_rd, n_wr, n_wrreg, n_zero, n_c} = {m_valid, m_rd, m_wr, m_wrreg, m_zero, m_c};
    {n_alu, n_sd, n_dst} = {m_alu, m_sd, m_dst};
    if (rst) begin
      {n_valid, n_rd, n_wr, n_wrreg, n_zero, n_c} = '0;
      {n_alu, n_sd, n_dst} = '0;
    end else if (bus.flush) begin
      {n_valid, n_rd, n_wr, n_wrreg} = '0;
    end else if (!bus.stall) begin
      n_valid = bus.id_ex_valid;
      n_alu   = r;
      n_sd    = fb;
      n_dst   = bus.id_ex_rfmt ? bus.id_ex_rd : bus.id_ex_rt;
      n_rd    = bus.id_ex_memrd && bus.id_ex_valid;
      n_wr    = bus.id_ex_memwr && bus.id_ex_valid;
      n_wrreg = bus.id_ex_wrreg && bus.id_ex_valid;
      n_zero  = (r == 0);
      if (bus.id_ex_valid && cop) n_c = c;
    end
    @(negedge clk);
    {m_valid, m_rd, m_wr, m_wrreg, m_zero, m_c} = {n_valid, n_rd, n_wr, n_wrreg, n_zero, n_c};
    {m_alu, m_sd, m_dst} = {n_alu, n_sd, n_dst};
    @(posedge clk);
    #1;
    // Data fields are unspecified after a flush, so only control is compared then.
    if (data_cmp) check_all(tag);
    else begin
      check({tag, "_valid"}, 32'(bus.ex_mem_valid), 32'(m_valid));
      check({tag, "_memrd"}, 32'(bus.ex_mem_memrd), 32'(m_rd));
      check({tag, "_memwr"}, 32'(bus.ex_mem_memwr), 32'(m_wr));
      check({tag, "_wrreg"}, 32'(bus.ex_mem_wrreg), 32'(m_wrreg));
      check({tag, "_flagc"}, 32'(bus.ex_flag_c), 32'(m_c));
    end
  endtask

  task automatic clear_inputs();
    bus.id_ex_valid = 0; bus.id_ex_opcode = 0; bus.id_ex_reg_0 = 0; bus.id_ex_reg_1 = 0;
    bus.id_ex_rs = 0; bus.id_ex_rt = 0; bus.id_ex_rd = 0; bus.id_ex_imm_se = 0;
    bus.id_ex_rfmt = 0; bus.id_ex_alusrc = 0; bus.id_ex_memrd = 0; bus.id_ex_memwr = 0;
    bus.id_ex_wrreg = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.mem_fwd_wrreg = 0; bus.mem_fwd_addr = 0; bus.mem_fwd_data = 0;
    bus.wb_fwd_wrreg = 0; bus.wb_fwd_addr = 0; bus.wb_fwd_data = 0;
    bus.stall = 0; bus.flush = 0;
  endtask

  logic [5:0] op_tab [12];
  bit         flushed;

  initial begin
    n_cmp = 0; n_bad = 0;
    op_tab = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h06, 6'h10, 6'h11, 6'h12, 6'h16, 6'h17, 6'h18};
    {m_valid, m_rd, m_wr, m_wrreg, m_zero, m_c} = '1;
    {m_alu, m_sd, m_dst} = '1;
    clear_inputs();
    rst = 1;
    tick("reset", 1);
    check("reset_flagc_zero", 32'(bus.ex_flag_c), 32'd0);
    rst = 0;

    // ADD with carry out
    clear_inputs();
    bus.id_ex_valid = 1; bus.id_ex_opcode = 6'h06; bus.id_ex_rfmt = 1; bus.id_ex_wrreg = 1;
    bus.id_ex_rs = 1; bus.id_ex_rt = 2; bus.id_ex_rd = 5;
    bus.id_ex_reg_0 = 32'hFFFF_FFFF; bus.id_ex_reg_1 = 32'h2;
    tick("add", 1);
    check("add_alu_lit", bus.ex_mem_alu, 32'h1);
    check("add_flagc_lit", 32'(bus.ex_flag_c), 32'd1);

    // SUB: MEM beats WB on rs
    clear_inputs();
    bus.id_ex_valid = 1; bus.id_ex_opcode = 6'h04; bus.id_ex_rfmt = 1; bus.id_ex_rd = 8;
    bus.id_ex_rs = 3; bus.id_ex_rt = 4; bus.id_ex_reg_1 = 32'h10;
    bus.mem_fwd_wrreg = 1; bus.mem_fwd_addr = 3; bus.mem_fwd_data = 32'h10;
    bus.wb_fwd_wrreg = 1; bus.wb_fwd_addr = 3; bus.wb_fwd_data = 32'h99;
    tick("sub_prio", 1);
    check("sub_prio_zero_lit", 32'(bus.ex_mem_zero), 32'd1);
    // SUB: WB forwards rt
    bus.id_ex_reg_1 = 32'h0; bus.wb_fwd_addr = 4; bus.wb_fwd_data = 32'h10;
    tick("sub_wbfwd", 1);
    check("sub_wbfwd_alu_lit", bus.ex_mem_alu, 32'h0);
    check("sub_wbfwd_sd_lit", bus.ex_mem_store_data, 32'h10);

    // LW with load-use hazard
    clear_inputs();
    bus.id_ex_valid = 1; bus.id_ex_opcode = 6'h16; bus.id_ex_alusrc = 1; bus.id_ex_memrd = 1;
    bus.id_ex_wrreg = 1; bus.id_ex_rs = 2; bus.id_ex_rt = 7; bus.id_ex_reg_0 = 32'h100;
    bus.id_ex_imm_se = 32'hFFFF_FFFC; bus.id_rs = 7; bus.id_rt = 9;
    bus.stall = 1; bus.flush = 1;
    #1;
    check("lw_load_use", 32'(bus.ex_load_use), 32'd1);
    bus.stall = 0; bus.flush = 0;
    tick("lw", 1);
    check("lw_alu_lit", bus.ex_mem_alu, 32'hFC);

    // Stall holds a valid ADD, then flush drops it
    clear_inputs();
    bus.id_ex_valid = 1; bus.id_ex_opcode = 6'h06; bus.id_ex_rfmt = 1; bus.id_ex_wrreg = 1;
    bus.id_ex_rd = 6; bus.id_ex_reg_0 = 32'h1234; bus.id_ex_reg_1 = 32'h1;
    tick("stall_load", 1);
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1; bus.id_ex_reg_0 = $urandom(); bus.id_ex_rd = 5'(i + 10);
      tick("stall_hold", 1);
    end
    check("stall_alu_lit", bus.ex_mem_alu, 32'h1235);
    bus.stall = 0; bus.flush = 1;
    tick("flush", 0);

    // r0 is never forwarded
    clear_inputs();
    bus.id_ex_valid = 1; bus.id_ex_opcode = 6'h18;
    bus.mem_fwd_wrreg = 1; bus.mem_fwd_addr = 0; bus.mem_fwd_data = 32'h55;
    tick("r0", 1);
    check("r0_alu_lit", bus.ex_mem_alu, 32'h0);

    // Reset while a SW is held by stall
    clear_inputs();
    bus.id_ex_valid = 1; bus.id_ex_opcode = 6'h17; bus.id_ex_alusrc = 1; bus.id_ex_memwr = 1;
    bus.id_ex_reg_0 = 32'h40; bus.id_ex_reg_1 = 32'hAB; bus.id_ex_imm_se = 32'h4; bus.id_ex_rt = 3;
    tick("sw", 1);
    bus.stall = 1; rst = 1;
    tick("rst_stall", 1);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.id_ex_valid   = ($urandom_range(0, 3) != 0);
      bus.id_ex_opcode  = ($urandom_range(0, 4) == 0) ? 6'($urandom()) : op_tab[$urandom_range(0, 11)];
      bus.id_ex_reg_0   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom();
      bus.id_ex_reg_1   = ($urandom_range(0, 3) == 0) ? bus.id_ex_reg_0 : $urandom();
      bus.id_ex_rs      = 5'($urandom_range(0, 3));
      bus.id_ex_rt      = 5'($urandom_range(0, 3));
      bus.id_ex_rd      = 5'($urandom_range(0, 3));
      bus.id_ex_imm_se  = $urandom();
      bus.id_ex_rfmt    = 1'($urandom());
      bus.id_ex_alusrc  = 1'($urandom());
      bus.id_ex_memrd   = 1'($urandom());
      bus.id_ex_memwr   = 1'($urandom());
      bus.id_ex_wrreg   = 1'($urandom());
      bus.id_rs         = 5'($urandom_range(0, 3));
      bus.id_rt         = 5'($urandom_range(0, 3));
      bus.mem_fwd_wrreg = 1'($urandom());
      bus.mem_fwd_addr  = 5'($urandom_range(0, 3));
      bus.mem_fwd_data  = $urandom();
      bus.wb_fwd_wrreg  = 1'($urandom());
      bus.wb_fwd_addr   = 5'($urandom_range(0, 3));
      bus.wb_fwd_data   = $urandom();
      bus.stall         = ($urandom_range(0, 5) == 0);
      bus.flush         = ($urandom_range(0, 7) == 0);
      rst               = ($urandom_range(0, 40) == 0);
      #1;
      check("rnd_load_use", 32'(bus.ex_load_use), 32'(exp_load_use()));
      flushed = bus.flush && !rst;
      tick("rnd", !flushed);
      // Resync model data fields after an unspecified flush by reloading a known value.
      if (flushed) begin
        rst = 1;
        tick("rnd_resync", 1);
      end
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zmips_ex_stage.md
ZMIPS_EX_STAGE -- requirements
Module: zmips_ex_stage

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  clock; all registers update on the falling edge
- rst  in  1  synchronous active-high reset, sampled on the falling edge of clk
- id_ex_valid  in  1  ID/EX holds a live instruction
- id_ex_opcode  in  6  opcode field
- id_ex_reg_0, id_ex_reg_1  in  32  register file rs/rt values
- id_ex_rs, id_ex_rt, id_ex_rd  in  5  register numbers
- id_ex_imm_se  in  32  sign-extended immediate
- id_ex_rfmt, id_ex_alusrc, id_ex_memrd, id_ex_memwr, id_ex_wrreg  in  1  control bits from ID
- id_rs, id_rt  in  5  source registers of the instruction currently in ID
- mem_fwd_wrreg  in  1  MEM stage will write a register
- mem_fwd_addr  in  5  MEM destination register
- mem_fwd_data  in  32  MEM result
- wb_fwd_wrreg  in  1  WB stage will write a register
- wb_fwd_addr  in  5  WB destination register
- wb_fwd_data  in  32  WB result
- stall  in  1  hold EX/MEM contents
- flush  in  1  insert bubble into EX/MEM
- ex_mem_valid  out  1  EX/MEM holds a live instruction
- ex_mem_alu  out  32  ALU result / memory address
- ex_mem_store_data  out  32  forwarded rt value for SW
- ex_mem_dst  out  5  destination register
- ex_mem_memrd, ex_mem_memwr, ex_mem_wrreg  out  1  registered control bits
- ex_mem_zero  out  1  registered (ALU result == 0)
- ex_flag_c  out  1  carry flag
- ex_load_use  out  1  combinational load-use hazard request

Function
REQ-002 Operand A SHALL be: mem_fwd_data if mem_fwd_wrreg, mem_fwd_addr==id_ex_rs and id_ex_rs!=0; else wb_fwd_data if wb_fwd_wrreg, wb_fwd_addr==id_ex_rs and id_ex_rs!=0; else id_ex_reg_0.
REQ-003 Forwarded B SHALL use the same rule on id_ex_rt/id_ex_reg_1. MEM has priority over WB. Register 0 is never forwarded.
REQ-004 Operand B SHALL be id_ex_imm_se when id_ex_alusrc=1, else forwarded B.
REQ-005 The ALU result SHALL be a 32-bit value, with carry taken from the 33rd bit, selected by opcode:
- 0x01: A&B
- 0x02: A|B
- 0x03: A^B
- 0x04, 0x10, 0x12, 0x13: A-B
- 0x06, 0x11, 0x16, 0x17: A+B
- 0x18: A
- all others, including 0x00: 0
REQ-006 Destination SHALL be id_ex_rd when id_ex_rfmt=1, else id_ex_rt.
REQ-007 ex_mem_store_data SHALL be forwarded B, never the immediate.
REQ-008 On a falling edge with rst=0, flush=0, stall=0, EX/MEM SHALL load:
- the ALU result, zero flag, destination and store data
- valid=id_ex_valid
- memrd/memwr/wrreg = input bit AND id_ex_valid
REQ-009 Latency SHALL be one clk cycle from ID/EX to EX/MEM.
REQ-010 When stall=1 and flush=0, all EX/MEM registers and ex_flag_c SHALL hold.
REQ-011 When flush=1, ex_mem_valid, memrd, memwr and wrreg SHALL clear, regardless of stall. Data fields are don't-care. ex_flag_c holds.
REQ-012 ex_flag_c SHALL update only on a valid, non-stalled, non-flushed instruction with opcode 0x04, 0x06, 0x10 or 0x11.
- Add: carry out.
- Subtract: 1 when no borrow (unsigned A>=B).
REQ-013 ex_load_use SHALL be 1 when all hold: id_ex_valid, id_ex_memrd, destination!=0, and destination==id_rs or destination==id_rt.
REQ-014 ex_load_use SHALL have no dependence on stall or flush.
REQ-015 Addition and subtraction SHALL wrap modulo 2^32, with no overflow trap.

Reset
REQ-016 On rst=1 at a falling edge, every registered output SHALL become 0, including ex_flag_c. rst SHALL take priority over stall and flush.
REQ-017 Reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ADD (0x06), reg_0=0xFFFFFFFF, reg_1=0x00000002, rd=5, no forwarding -> next edge: alu=0x00000001, dst=5, flag_c=1, zero=0.
- SUB (0x04), rs=3, rt=4; mem_fwd writes r3=0x10; wb_fwd writes r3=0x99 and r4=0x10 -> alu=0x0, zero=1, flag_c=1 (MEM priority on A).
- LW (0x16), rt=7, imm=0xFFFFFFFC, reg_0=0x100; id_rs=7 -> ex_load_use=1 combinationally; next edge: alu=0xFC, memrd=1, wrreg=1, dst=7.
- Valid ADD with stall=1 for 3 cycles -> outputs unchanged; then stall=0 and flush=1 -> valid=0, wrreg=0, flag_c unchanged.
- Forward to rs=0 with mem_fwd_addr=0, mem_fwd_data=0x55, reg_0=0 -> A=0, no forwarding.
- rst=1 during stall with a valid SW held -> all outputs 0 on next edge.
